// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 5;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract the divisor from the shifted partial remainder.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem_shift_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_next_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] diff;

    // The shifted remainder is below 2*divisor, so the top bit of the
    // WIDTH+1 bit difference is exactly the borrow.
    always_comb begin
        diff       = rem_shift_i - {1'b0, divisor_i};
        q_bit_o    = ~diff[WIDTH];
        rem_next_o = q_bit_o ? diff[WIDTH-1:0] : rem_shift_i[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock under a start/busy/done handshake.
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder, always < divisor
    logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             pend_q, pend_d;     // divide-by-zero result due on the next edge

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_shift_i ({rem_q, dvd_q[WIDTH-1]}),
        .divisor_i   (dvs_q),
        .rem_next_o  (step_rem),
        .q_bit_o     (step_q)
    );

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        pend_d  = 1'b0;

        if (pend_q) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
            quot_d = '1;
            remo_d = dvd_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    rem_d = '0;
                    cnt_d = CW'(WIDTH - 1);
                    if (divisor != '0) state_d = RUN;
                    else               pend_d  = 1'b1;
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = WIDTH'({dvd_q, step_q});
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    dbz_d   = 1'b0;
                    quot_d  = WIDTH'({dvd_q, step_q});
                    remo_d  = step_rem;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div against an arithmetic reference model.
module tb_seq_div;

    localparam int W = 5;
    localparam int ALL_ONES = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    int n_total = 0;
    int n_bad   = 0;
    int prev_q  = 0;
    int prev_r  = 0;

    seq_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_div(input int a, input int b);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // lat0 = edges elapsed since the accepting edge at entry.
    task automatic wait_done(input int a, input int b, input int lat0, input string tag);
        int  lat;
        bit  saw_busy;
        int  exp_q;
        int  exp_r;
        lat      = lat0;
        saw_busy = 0;
        exp_q    = (b == 0) ? ALL_ONES : a / b;
        exp_r    = (b == 0) ? a : a % b;
        if (lat0 == 0) begin
            check({tag, " hold_q"}, quotient, prev_q);
            check({tag, " hold_r"}, remainder, prev_r);
        end
        while (done !== 1'b1 && lat <= W + 3) begin
            if (busy === 1'b1) saw_busy = 1;
            @(negedge clk);
            lat++;
        end
        check({tag, " done"}, done, 1);
        check({tag, " latency"}, lat, (b == 0) ? 1 : W);
        check({tag, " quot"}, quotient, exp_q);
        check({tag, " rem"}, remainder, exp_r);
        check({tag, " dbz"}, dbz, (b == 0) ? 1 : 0);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " saw_busy"}, saw_busy, (b != 0) ? 1 : 0);
        prev_q = exp_q;
        prev_r = exp_r;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, " done_clear"}, done, 0);
        check({tag, " idle"}, busy, 0);
    endtask

    initial begin
        int seen_done;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst quot", quotient, 0);
        check("rst rem", remainder, 0);
        check("rst dbz", dbz, 0);
        rst = 1'b0;
        @(negedge clk);

        start_div(20, 3);
        wait_done(20, 3, 0, "20/3");
        idle_check("20/3");

        start_div(31, 1);
        wait_done(31, 1, 0, "31/1");
        start_div(7, 9);
        wait_done(7, 9, 0, "7/9 b2b");
        idle_check("7/9");

        start_div(13, 0);
        wait_done(13, 0, 0, "13/0");
        idle_check("13/0");
        start_div(12, 4);
        wait_done(12, 4, 0, "12/4");
        idle_check("12/4");

        start_div(25, 5);
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(30);
        divisor  = W'(2);
        @(negedge clk);
        start    = 1'b0;
        wait_done(25, 5, 2, "25/5 ignore");
        idle_check("25/5");

        start_div(29, 4);
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort quot", quotient, 0);
        check("abort rem", remainder, 0);
        check("abort dbz", dbz, 0);
        @(negedge clk);
        rst    = 1'b0;
        prev_q = 0;
        prev_r = 0;
        seen_done = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        check("abort no_done", seen_done, 0);
        start_div(29, 4);
        wait_done(29, 4, 0, "29/4 fresh");
        idle_check("29/4");

        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 1; b < (1 << W); b++) begin
                start_div(a, b);
                wait_done(a, b, 0, $sformatf("sweep %0d/%0d", a, b));
                idle_check("sweep");
            end
        end

        for (int i = 0; i < 80; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, ALL_ONES));
            b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, ALL_ONES));
            start_div(a, b);
            wait_done(a, b, 0, $sformatf("rand %0d/%0d", a, b));
            if ($urandom_range(0, 1) == 1) idle_check("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Sequential restoring divider: the inverse operation of the team's sum-and-multiply block.
- Takes a WIDTH-bit product-style dividend and a WIDTH-bit divisor, and returns quotient and remainder.
- Computes one quotient bit per clock, under a start/busy/done handshake.
- Sits downstream of the multiply datapath and recovers an operand from a product.

Parameters:
- WIDTH, 5, bit width of dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled on posedge only when idle.
- dividend  input  WIDTH  numerator; captured on accepted start.
- divisor  input  WIDTH  denominator; captured on accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse: results valid.
- quotient  output  WIDTH  floor(dividend/divisor).
- remainder  output  WIDTH  dividend mod divisor.
- dbz  output  1  divide-by-zero flag for the last result.

Behaviour:
- Reset: asynchronous, active-high.
  - While rst=1: busy=0, done=0, quotient=0, remainder=0, dbz=0, state=IDLE, counter=0, internal regs cleared.
  - Reset asserted mid-division aborts it; no done pulse is produced.
- States: IDLE, RUN.
- IDLE, start=1 sampled at edge N (start accepted):
  - Capture dividend and divisor into internal registers.
  - Partial remainder register (WIDTH+1 bits) = 0.
  - counter = WIDTH-1.
  - If divisor != 0: go to RUN, busy=1 from edge N.
  - If divisor == 0: stay IDLE, busy stays 0.
    - At edge N+1: done=1, dbz=1, quotient = all ones, remainder = captured dividend.
- RUN, each edge:
  - Shift the partial remainder left by 1 and bring in the dividend MSB (the dividend register shifts left).
  - Trial subtract the divisor, zero-extended to WIDTH+1 bits.
  - Non-negative result: keep it, shift in quotient bit 1. Negative result: restore the previous value, shift in 0.
  - Decrement counter.
- RUN exit:
  - The edge that processes counter==0 is edge N+WIDTH.
  - At that edge: quotient and remainder outputs load the final values, done=1, dbz=0, busy=0, state=IDLE.
- Latency:
  - Normal division: done high in the cycle after edge N+WIDTH (WIDTH cycles after acceptance).
  - Divide-by-zero: 1 cycle after acceptance.
- done pulse:
  - High for exactly one cycle.
  - Auto-clears on the next edge unless a new divide-by-zero completes on that edge.
- Output hold: quotient, remainder and dbz hold their values until the next completion. They are not cleared by a new start.
- start while busy=1: ignored; operands are not recaptured.
- start high during the done cycle: accepted, because state is already IDLE. This gives back-to-back operation with no dead cycle.
- start held high continuously: a new division starts every time the block returns to IDLE.
- dividend < divisor: quotient=0, remainder=dividend.
- divisor=1: quotient=dividend, remainder=0.
- Arithmetic:
  - Unsigned only.
  - Intermediate subtraction is WIDTH+1 bits so the borrow is detectable.
  - No overflow is possible for a nonzero divisor.
- Inputs are sampled only at the accepting edge; later changes to dividend/divisor have no effect.

Decomposition:
- Shared package (div_pkg):
  - state enum {IDLE, RUN}.
  - Default WIDTH constant.
  - Counter width constant, $clog2(WIDTH).
- Sub-module (optional but natural): div_step.
  - Combinational: takes the shifted partial remainder and the divisor.
  - Returns the next partial remainder and the quotient bit.
  - Keeps the FSM/datapath split clean and reusable for an unrolled variant.

Test Plan:
- 20/3, WIDTH=5: start at edge N -> busy=1 for 5 cycles; at edge N+5, done=1, quotient=6, remainder=2, dbz=0.
- 31/1 then 7/9, back-to-back, with start high in the done cycle -> first result quotient=31, remainder=0. Second accepted with no gap: quotient=0, remainder=7, done 5 cycles later.
- 13/0 -> at edge N+1, done=1, dbz=1, quotient=31, remainder=13, busy never 1. A following 12/4 gives dbz=0, quotient=3, remainder=0.
- 25/5 started, then start pulsed with 30/2 at cycle 2 of RUN -> ignored; result quotient=5, remainder=0 at N+5.
- 29/4 started, rst pulsed at cycle 3 (asynchronous, mid-cycle) -> all outputs 0 immediately, no done pulse. A fresh 29/4 afterwards gives quotient=7, remainder=1.
- Exhaustive sweep of all 32x31 nonzero-divisor pairs against a reference model -> every quotient/remainder matches, done exactly once per start.
